// File: rtl/arc_pkg.sv
// Shared definitions for the arc step generator: coordinate widths, op flag
// layout, FSM state encoding and the signed step encoding.
package arc_pkg;

    localparam int PRECISE_POS_X_BITS = 16;
    localparam int PRECISE_POS_Y_BITS = 16;
    localparam int OP_FLAGS_BITS      = 4;

    localparam int ARC_FLAG_CW   = 0;
    localparam int ARC_FLAG_FULL = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_CALC = 3'd2,
        ST_EMIT = 3'd3,
        ST_FIN  = 3'd4
    } arc_state_t;

    localparam logic signed [1:0] STEP_POS  = 2'sb01;
    localparam logic signed [1:0] STEP_ZERO = 2'sb00;
    localparam logic signed [1:0] STEP_NEG  = 2'sb11;

    // Unit step toward the sign of a value, optionally negated first.
    function automatic logic signed [1:0] step_dir(input logic is_zero,
                                                   input logic is_neg,
                                                   input logic negate);
        logic signed [1:0] dir;
        if (is_zero) begin
            dir = STEP_ZERO;
        end else if (is_neg ^ negate) begin
            dir = STEP_NEG;
        end else begin
            dir = STEP_POS;
        end
        return dir;
    endfunction

endpackage

// File: rtl/arc_step_chooser.sv
// Combinational step selection: evaluates the axis and diagonal moves along the
// tangent and picks the one keeping x^2+y^2 closest to the start radius.
module arc_step_chooser
    import arc_pkg::*;
#(
    parameter int XW = PRECISE_POS_X_BITS,
    parameter int YW = PRECISE_POS_Y_BITS,
    parameter int EW = XW + YW + 2
) (
    input  logic signed [XW-1:0] cur_x_i,
    input  logic signed [YW-1:0] cur_y_i,
    input  logic signed [EW-1:0] err_i,
    input  logic                 cw_i,
    output logic signed [1:0]    dx_o,
    output logic signed [1:0]    dy_o,
    output logic signed [EW-1:0] err_nxt_o
);

    localparam logic signed [EW-1:0] ONE_E = EW'(1'b1);

    function automatic logic [EW-1:0] mag(input logic signed [EW-1:0] v);
        logic [EW-1:0] m;
        if (v[EW-1]) begin
            m = -v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    logic signed [1:0]    tx_dir_s, ty_dir_s, sx_s, sy_s;
    logic signed [EW-1:0] x2_s, y2_s, ex_s, ey_s, e0_s, e1_s, e2_s;
    logic [EW-1:0]        a0_s, a1_s, a2_s, best01_s;
    logic                 take1_s, take2_s;

    // CCW tangent is (-y, x); CW tangent is (y, -x).
    assign tx_dir_s = step_dir(cur_y_i == '0, cur_y_i[YW-1], ~cw_i);
    assign ty_dir_s = step_dir(cur_x_i == '0, cur_x_i[XW-1], cw_i);
    // At the centre there is no tangent; fall back to a +X step so a step is always produced.
    assign sx_s = (tx_dir_s == STEP_ZERO && ty_dir_s == STEP_ZERO) ? STEP_POS : tx_dir_s;
    assign sy_s = ty_dir_s;

    assign x2_s = EW'(cur_x_i) <<< 1;
    assign y2_s = EW'(cur_y_i) <<< 1;

    // Change of x^2 (resp. y^2) for a unit move: +-2v + 1.
    always_comb begin
        case (sx_s)
            STEP_POS: ex_s = x2_s + ONE_E;
            STEP_NEG: ex_s = ONE_E - x2_s;
            default:  ex_s = '0;
        endcase
        case (sy_s)
            STEP_POS: ey_s = y2_s + ONE_E;
            STEP_NEG: ey_s = ONE_E - y2_s;
            default:  ey_s = '0;
        endcase
    end

    assign e0_s = err_i + ex_s;
    assign e1_s = err_i + ey_s;
    assign e2_s = err_i + ex_s + ey_s;
    assign a0_s = mag(e0_s);
    assign a1_s = mag(e1_s);
    assign a2_s = mag(e2_s);

    // Strict compares give ties to the earlier candidate: X, then Y, then diagonal.
    assign take1_s  = (sy_s != STEP_ZERO) && ((sx_s == STEP_ZERO) || (a1_s < a0_s));
    assign best01_s = take1_s ? a1_s : a0_s;
    assign take2_s  = (sx_s != STEP_ZERO) && (sy_s != STEP_ZERO) && (a2_s < best01_s);

    // Drive the selected candidate.
    always_comb begin
        if (take2_s) begin
            dx_o      = sx_s;
            dy_o      = sy_s;
            err_nxt_o = e2_s;
        end else if (take1_s) begin
            dx_o      = STEP_ZERO;
            dy_o      = sy_s;
            err_nxt_o = e1_s;
        end else begin
            dx_o      = sx_s;
            dy_o      = STEP_ZERO;
            err_nxt_o = e0_s;
        end
    end

endmodule

// File: rtl/arc_step_generator.sv
// Walks a G02/G03 arc on the integer grid, emitting one unit (dx, dy) step per
// handshake until the end point is reached or the step limit aborts the op.
module arc_step_generator
    import arc_pkg::*;
#(
    parameter int POS_X_BITS = PRECISE_POS_X_BITS,
    parameter int POS_Y_BITS = PRECISE_POS_Y_BITS,
    parameter int STEP_LIMIT = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [POS_X_BITS-1:0]    start_x,
    input  logic [POS_Y_BITS-1:0]    start_y,
    input  logic [POS_X_BITS-1:0]    end_x,
    input  logic [POS_Y_BITS-1:0]    end_y,
    input  logic [OP_FLAGS_BITS-1:0] flags,
    output logic                     step_valid,
    input  logic                     step_ready,
    output logic [1:0]               step_dx,
    output logic [1:0]               step_dy,
    output logic                     done,
    output logic                     aborted
);

    localparam int ERR_BITS = POS_X_BITS + POS_Y_BITS + 2;
    localparam int CNT_BITS = $clog2(STEP_LIMIT + 1);
    localparam logic [CNT_BITS-1:0] CNT_LIMIT = CNT_BITS'(STEP_LIMIT);

    arc_state_t                    state_q, state_d;
    logic signed [POS_X_BITS-1:0]  cur_x_q, cur_x_d, end_x_q, end_x_d;
    logic signed [POS_Y_BITS-1:0]  cur_y_q, cur_y_d, end_y_q, end_y_d;
    logic                          cw_q, cw_d, full_q, full_d;
    logic signed [ERR_BITS-1:0]    err_q, err_d, err_nxt_q, err_nxt_d;
    logic signed [1:0]             step_dx_q, step_dx_d, step_dy_q, step_dy_d;
    logic [CNT_BITS-1:0]           step_cnt_q, step_cnt_d;
    logic                          aborted_q, aborted_d;
    logic                          start_ready_q, step_valid_q, done_q;
    logic signed [1:0]             ch_dx_s, ch_dy_s;
    logic signed [ERR_BITS-1:0]    ch_err_s;
    logic                          unused_flags_s;

    assign unused_flags_s = &{1'b0, flags[OP_FLAGS_BITS-1:2]};

    // err tracks x^2+y^2 - r^2 incrementally from zero, so r^2 itself is never formed.
    arc_step_chooser #(
        .XW (POS_X_BITS),
        .YW (POS_Y_BITS),
        .EW (ERR_BITS)
    ) u_chooser (
        .cur_x_i   (cur_x_q),
        .cur_y_i   (cur_y_q),
        .err_i     (err_q),
        .cw_i      (cw_q),
        .dx_o      (ch_dx_s),
        .dy_o      (ch_dy_s),
        .err_nxt_o (ch_err_s)
    );

    // Next-state and datapath updates for the arc walk.
    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        end_x_d    = end_x_q;
        end_y_d    = end_y_q;
        cw_d       = cw_q;
        full_d     = full_q;
        err_d      = err_q;
        err_nxt_d  = err_nxt_q;
        step_dx_d  = step_dx_q;
        step_dy_d  = step_dy_q;
        step_cnt_d = step_cnt_q;
        aborted_d  = aborted_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid && start_ready_q) begin
                    cur_x_d    = start_x;
                    cur_y_d    = start_y;
                    end_x_d    = end_x;
                    end_y_d    = end_y;
                    cw_d       = flags[ARC_FLAG_CW];
                    full_d     = flags[ARC_FLAG_FULL];
                    step_cnt_d = '0;
                    aborted_d  = 1'b0;
                    state_d    = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                err_d = '0;
                if (cur_x_q == end_x_q && cur_y_q == end_y_q && !full_q) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                step_dx_d = ch_dx_s;
                step_dy_d = ch_dy_s;
                err_nxt_d = ch_err_s;
                state_d   = ST_EMIT;
            end
            ST_EMIT: begin
                if (step_ready) begin
                    cur_x_d    = cur_x_q + POS_X_BITS'(step_dx_q);
                    cur_y_d    = cur_y_q + POS_Y_BITS'(step_dy_q);
                    err_d      = err_nxt_q;
                    step_cnt_d = step_cnt_q + CNT_BITS'(1'b1);
                    if (cur_x_d == end_x_q && cur_y_d == end_y_q &&
                        (!full_q || step_cnt_d != '0)) begin
                        state_d = ST_FIN;
                    end else if (step_cnt_d == CNT_LIMIT) begin
                        aborted_d = 1'b1;
                        state_d   = ST_FIN;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cur_x_q       <= '0;
            cur_y_q       <= '0;
            end_x_q       <= '0;
            end_y_q       <= '0;
            cw_q          <= 1'b0;
            full_q        <= 1'b0;
            err_q         <= '0;
            err_nxt_q     <= '0;
            step_dx_q     <= STEP_ZERO;
            step_dy_q     <= STEP_ZERO;
            step_cnt_q    <= '0;
            aborted_q     <= 1'b0;
            start_ready_q <= 1'b1;
            step_valid_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_x_q       <= cur_x_d;
            cur_y_q       <= cur_y_d;
            end_x_q       <= end_x_d;
            end_y_q       <= end_y_d;
            cw_q          <= cw_d;
            full_q        <= full_d;
            err_q         <= err_d;
            err_nxt_q     <= err_nxt_d;
            step_dx_q     <= step_dx_d;
            step_dy_q     <= step_dy_d;
            step_cnt_q    <= step_cnt_d;
            aborted_q     <= aborted_d;
            start_ready_q <= (state_d == ST_IDLE);
            step_valid_q  <= (state_d == ST_EMIT);
            done_q        <= (state_d == ST_FIN);
        end
    end

    assign start_ready = start_ready_q;
    assign step_valid  = step_valid_q;
    assign step_dx     = step_dx_q;
    assign step_dy     = step_dy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_arc_step_generator.sv
// Self-checking bench for arc_step_generator: directed arcs plus randomized arcs
// and backpressure, compared against a squared-radius reference walk.
`timescale 1ns/1ps
module tb_arc_step_generator;
    import arc_pkg::*;

    localparam int XB    = 16;
    localparam int YB    = 16;
    localparam int LIMIT = 16;

    logic                     clk;
    logic                     reset;
    logic                     start_valid, start_ready;
    logic [XB-1:0]            start_x, end_x;
    logic [YB-1:0]            start_y, end_y;
    logic [OP_FLAGS_BITS-1:0] flags;
    logic                     step_valid, step_ready;
    logic [1:0]               step_dx, step_dy;
    logic                     done, aborted;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    arc_step_generator #(
        .POS_X_BITS (XB),
        .POS_Y_BITS (YB),
        .STEP_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_x     (start_x),
        .start_y     (start_y),
        .end_x       (end_x),
        .end_y       (end_y),
        .flags       (flags),
        .step_valid  (step_valid),
        .step_ready  (step_ready),
        .step_dx     (step_dx),
        .step_dy     (step_dy),
        .done        (done),
        .aborted     (aborted)
    );

    typedef struct {
        int dx;
        int dy;
    } step_t;

    step_t exp_q[$];
    bit    exp_abort;
    bit    exp_zero;
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    bit    first_pending = 1'b0;
    int    ready_mode = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    // Reference walk: greedy unit moves along the tangent keeping x^2+y^2 nearest r^2.
    task automatic model_walk(input int sx, input int sy, input int ex, input int ey,
                              input bit cw, input bit full);
        int x, y, r2, gx, gy, bx, by, bd, d, mx, my;
        exp_q.delete();
        exp_abort = 1'b0;
        x = sx;
        y = sy;
        r2 = sx * sx + sy * sy;
        if (x == ex && y == ey && !full) return;
        for (int n = 1; n <= LIMIT; n++) begin
            gx = sgn(cw ? y : -y);
            gy = sgn(cw ? -x : x);
            if (gx == 0 && gy == 0) gx = 1;
            bd = -1;
            bx = 0;
            by = 0;
            for (int k = 0; k < 3; k++) begin
                mx = (k == 1) ? 0 : gx;
                my = (k == 0) ? 0 : gy;
                if ((mx == 0 && my == 0) || (k == 2 && (mx == 0 || my == 0))) continue;
                d = (x + mx) * (x + mx) + (y + my) * (y + my) - r2;
                if (d < 0) d = -d;
                if (bd < 0 || d < bd) begin
                    bd = d;
                    bx = mx;
                    by = my;
                end
            end
            x += bx;
            y += by;
            exp_q.push_back('{dx: bx, dy: by});
            if (x == ex && y == ey) return;
            if (n == LIMIT) exp_abort = 1'b1;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ready driver: 0 = tied high, 1 = five stall cycles per step, 2 = random.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        step_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1: begin
                    if (step_valid && stall_cnt < 5) begin
                        step_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        step_ready = 1'b1;
                        if (step_valid) stall_cnt = 0;
                    end
                end
                2: begin
                    step_ready = ($urandom_range(0, 1) == 1);
                    stall_cnt = 0;
                end
                default: begin
                    step_ready = 1'b1;
                    stall_cnt = 0;
                end
            endcase
        end
    end

    // Compare process: steps, stall stability, latencies and completion flags.
    initial begin
        bit    stall_prev;
        logic [1:0] prev_dx, prev_dy;
        step_t e;
        stall_prev = 1'b0;
        prev_dx = 2'b00;
        prev_dy = 2'b00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (start_valid && start_ready) begin
                    acc_cyc = cyc;
                    first_pending = 1'b1;
                end
                if (step_valid) begin
                    if (first_pending) begin
                        chk("first_step_latency", cyc - acc_cyc, 3);
                        first_pending = 1'b0;
                    end
                    if (stall_prev) begin
                        chk("stall_dx", longint'(step_dx), longint'(prev_dx));
                        chk("stall_dy", longint'(step_dy), longint'(prev_dy));
                        chk("stall_start_ready", start_ready, 0);
                    end
                    if (step_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("extra_step", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("step_dx", longint'($signed(step_dx)), e.dx);
                            chk("step_dy", longint'($signed(step_dy)), e.dy);
                        end
                        stall_prev = 1'b0;
                    end else begin
                        stall_prev = 1'b1;
                        prev_dx = step_dx;
                        prev_dy = step_dy;
                    end
                end else begin
                    stall_prev = 1'b0;
                end
                if (done) begin
                    chk("done_aborted", aborted, exp_abort);
                    chk("steps_remaining", exp_q.size(), 0);
                    if (exp_zero) chk("zero_arc_done_latency", cyc - acc_cyc, 2);
                    first_pending = 1'b0;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic launch(input int sx, input int sy, input int ex, input int ey, input int fl);
        @(posedge clk);
        #2;
        start_x = XB'(sx);
        start_y = YB'(sy);
        end_x = XB'(ex);
        end_y = YB'(ey);
        flags = OP_FLAGS_BITS'(fl);
        start_valid = 1'b1;
        @(posedge clk);
        #2;
        start_valid = 1'b0;
    endtask

    task automatic run_arc(input int sx, input int sy, input int ex, input int ey,
                           input int fl, input int mode);
        bit got;
        model_walk(sx, sy, ex, ey, fl[ARC_FLAG_CW], fl[ARC_FLAG_FULL]);
        exp_zero = (exp_q.size() == 0);
        ready_mode = mode;
        launch(sx, sy, ex, ey, fl);
        if (mode == 1) begin
            // An op offered mid-arc must be ignored.
            repeat (4) @(posedge clk);
            #2;
            start_x = XB'(7);
            start_y = YB'(7);
            start_valid = 1'b1;
            @(posedge clk);
            #2;
            start_valid = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", got, 1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        int t1x[3] = '{0, -1, -1};
        int t1y[3] = '{1, 1, 0};
        int t2x[3] = '{1, 1, 0};
        int t2y[3] = '{0, -1, -1};
        int t3x[8] = '{0, -1, -1, 0, 0, 1, 1, 0};
        int t3y[8] = '{1, 0, 0, -1, -1, 0, 0, 1};
        bit seen;

        reset = 1'b1;
        start_valid = 1'b0;
        start_x = '0;
        start_y = '0;
        end_x = '0;
        end_y = '0;
        flags = '0;
        exp_abort = 1'b0;
        exp_zero = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_start_ready", start_ready, 1);
        chk("reset_step_valid", step_valid, 0);
        chk("reset_step_dx", longint'(step_dx), 0);
        chk("reset_step_dy", longint'(step_dy), 0);
        chk("reset_done", done, 0);
        chk("reset_aborted", aborted, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Pin the reference walk against hand-derived sequences.
        model_walk(2, 0, 0, 2, 1'b0, 1'b0);
        chk("model_t1_len", exp_q.size(), 3);
        for (int i = 0; i < 3 && i < exp_q.size(); i++) begin
            chk("model_t1_dx", exp_q[i].dx, t1x[i]);
            chk("model_t1_dy", exp_q[i].dy, t1y[i]);
        end
        model_walk(0, 2, 2, 0, 1'b1, 1'b0);
        chk("model_t2_len", exp_q.size(), 3);
        for (int i = 0; i < 3 && i < exp_q.size(); i++) begin
            chk("model_t2_dx", exp_q[i].dx, t2x[i]);
            chk("model_t2_dy", exp_q[i].dy, t2y[i]);
        end
        model_walk(1, 0, 1, 0, 1'b0, 1'b1);
        chk("model_t3_len", exp_q.size(), 8);
        for (int i = 0; i < 8 && i < exp_q.size(); i++) begin
            chk("model_t3_dx", exp_q[i].dx, t3x[i]);
            chk("model_t3_dy", exp_q[i].dy, t3y[i]);
        end
        model_walk(2, 0, 5, 5, 1'b0, 1'b0);
        chk("model_t6_len", exp_q.size(), 16);
        chk("model_t6_abort", exp_abort, 1);

        run_arc(2, 0, 0, 2, 0, 0);
        run_arc(0, 2, 2, 0, 1, 0);
        run_arc(1, 0, 1, 0, 2, 0);
        run_arc(0, 0, 0, 0, 0, 0);
        run_arc(2, 0, 0, 2, 0, 1);
        run_arc(2, 0, 5, 5, 0, 0);

        // Reset in the middle of a stalled arc discards it.
        model_walk(2, 0, 5, 5, 1'b0, 1'b0);
        exp_zero = 1'b0;
        ready_mode = 1;
        launch(2, 0, 5, 5, 0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (step_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rerun_step_valid_seen", seen, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midarc_reset_step_valid", step_valid, 0);
        chk("midarc_reset_start_ready", start_ready, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        first_pending = 1'b0;
        ready_mode = 0;

        for (int i = 0; i < 40; i++) begin
            int sx, sy, ex, ey, fl, mode;
            sx = int'($urandom_range(0, 6)) - 3;
            sy = int'($urandom_range(0, 6)) - 3;
            ex = int'($urandom_range(0, 6)) - 3;
            ey = int'($urandom_range(0, 6)) - 3;
            fl = int'($urandom_range(0, 15));
            if (fl[ARC_FLAG_FULL]) begin
                ex = sx;
                ey = sy;
            end
            mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
            run_arc(sx, sy, ex, ey, fl, mode);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arc_step_generator.md
# arc_step_generator

Consumer end of the circular-motion op: takes a G02/G03 arc op and walks it on the integer grid as a stream of unit steps. Inputs are start and end points relative to the arc centre, plus the op flags. Output is one step per handshake, in the form (dx, dy) ∈ {−1, 0, +1}². It sits between the op decoder and the motor step scheduler and replaces per-op software interpolation.

## Interface
- `POS_X_BITS`, default `PRECISE_POS_X_BITS`: signed coordinate width, X.
- `POS_Y_BITS`, default `PRECISE_POS_Y_BITS`: signed coordinate width, Y.
- `STEP_LIMIT`, default 65535: maximum steps per arc before abort.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start_valid` in 1: arc op offered.
- `start_ready` out 1: high only in IDLE; an op is accepted when `start_valid && start_ready`.
- `start_x`, `start_y` in POS_X_BITS/POS_Y_BITS: start point minus centre (signed).
- `end_x`, `end_y` in POS_X_BITS/POS_Y_BITS: end point minus centre (signed).
- `flags` in `OP_FLAGS_BITS`: bit 0 = clockwise, bit 1 = full circle; other bits ignored.
- `step_valid` out 1: step offered.
- `step_ready` in 1: step consumed when `step_valid && step_ready`.
- `step_dx`, `step_dy` out 2: signed step, values −1, 0 or +1; never both 0 while valid.
- `done` out 1: one-cycle pulse at arc completion.
- `aborted` out 1: qualifies `done`; high when `STEP_LIMIT` was hit. Held until the next accept.

## Operation
- States: IDLE, INIT, CALC, EMIT, FIN.
- **IDLE.** On accept, latch start, end and flags into cur_x/cur_y, end regs and cw/full; clear step_cnt and `aborted`. Go to INIT.
- **INIT.** Compute r2 = start_x² + start_y² (width POS_X_BITS + POS_Y_BITS + 1) and set err = 0 (signed, r2 width + 1).
  - If cur == end and !full, go to FIN (zero steps).
  - Otherwise go to CALC.
- **CALC.** Compute the tangent: CCW gives tx = −cur_y, ty = cur_x; CW gives tx = cur_y, ty = −cur_x.
  - Candidates: (sgn tx, 0), (0, sgn ty), (sgn tx, sgn ty). Drop any zero move; drop duplicates.
  - For each candidate, err' = err + (dx ? 2·cur_x·dx + 1 : 0) + (dy ? 2·cur_y·dy + 1 : 0). This uses add/subtract only, no multiplier.
  - Pick the minimum |err'|. Tie priority: X-axis, then Y-axis, then diagonal.
  - Register the chosen step and err', then go to EMIT.
- **EMIT.** `step_valid` = 1; `step_dx`/`step_dy` stay stable until the handshake. On handshake:
  - Update cur and err; step_cnt++.
  - If cur == end and (!full or step_cnt ≥ 1), go to FIN.
  - Else if step_cnt == STEP_LIMIT, set `aborted` and go to FIN.
  - Else go to CALC.
- **FIN.** `done` = 1 for one cycle, then go to IDLE.
- Full circle requires end == start; the block terminates on the first return to start.

## Timing
- Reset values: state IDLE, `start_ready` 1, `step_valid` 0, `step_dx`/`step_dy` 0, `done` 0, `aborted` 0, all internal regs 0.
- Accept at cycle N: INIT at N+1, CALC at N+2, first `step_valid` at N+3.
- With `step_ready` tied high, the step rate is one per 2 cycles (CALC, EMIT).
- Backpressure: EMIT holds indefinitely; outputs do not change while `step_ready` = 0.
- A zero-length arc pulses `done` at N+2 with no step.
- `start_valid` outside IDLE is ignored; the op is not queued.
- `reset` in any state returns to IDLE on the next edge and drops `step_valid` the same edge. Any partial arc is discarded.

## Structure
- Shared package `arc_pkg`:
  - flag bit indices `ARC_FLAG_CW` = 0 and `ARC_FLAG_FULL` = 1;
  - state enum `arc_state_t`;
  - step encoding constants.
- One natural sub-module, `arc_step_chooser`: combinational candidate/error evaluation used in CALC. Inputs cur, err, cw; outputs dx, dy, err'.
- The top level holds the FSM, registers, counter and handshake.

## Test plan
1. CCW quarter, start (2,0), end (0,2), flags 0, ready high → steps (0,+1), (−1,+1), (−1,0); `done` with `aborted` 0; first step 3 cycles after accept.
2. CW quarter, start (0,2), end (2,0), flags 1 → steps (+1,0), (+1,−1), (0,−1); `done`.
3. Full circle r=1 CCW, start = end = (1,0), flags 2 → 8 steps: (0,+1), (−1,0), (−1,0), (0,−1), (0,−1), (+1,0), (+1,0), (0,+1); `done`.
4. Zero-length arc, start = end = (0,0), flags 0 → no `step_valid`; `done` 2 cycles after accept.
5. Backpressure: test 1 with `step_ready` low for 5 cycles on each step → identical sequence; outputs stable while stalled; `start_ready` low throughout.
6. Unreachable end, STEP_LIMIT = 16, start (2,0), end (5,5), CCW → exactly 16 steps, then `done` with `aborted` = 1. Then assert `reset` mid-arc on a rerun → `step_valid` 0 and `start_ready` 1 after one edge.
